// File: rtl/dense_layer_engine.sv
// Streaming fixed-point MAC engine: one dense-layer neuron per transaction
// (interleaved weight/activation pairs, then bias), saturated with optional ReLU.
module dense_layer_engine #(
  parameter int DATA_W    = 32,
  parameter int FRAC_W    = 24,
  parameter int LEN_W     = 16,
  parameter int ACC_GUARD = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LEN_W-1:0]         length,
  input  logic                     relu_en,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic                     busy
);

  localparam int ACC_W  = DATA_W + ACC_GUARD;
  localparam int PROD_W = 2 * DATA_W;
  localparam int WIDE_W = PROD_W + 1;

  typedef enum logic [2:0] {IDLE, WEIGHT, ACT, BIAS, OUT} state_t;

  state_t                    state_q, state_d;
  logic [LEN_W-1:0]          len_q, len_d, cnt_q, cnt_d;
  logic                      relu_q, relu_d, ovf_q, ovf_d;
  logic signed [DATA_W-1:0]  w_q, w_d, out_data_q, out_data_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;

  // Returns {clipped, value}: clips a wide two's-complement value to ACC_W bits.
  function automatic logic [ACC_W:0] sat_acc(input logic [WIDE_W-1:0] v);
    if ((&v[WIDE_W-1:ACC_W-1]) || ~(|v[WIDE_W-1:ACC_W-1]))
      return {1'b0, v[ACC_W-1:0]};
    else if (v[WIDE_W-1])
      return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  function automatic logic [DATA_W:0] sat_out(input logic [ACC_W-1:0] v);
    if ((&v[ACC_W-1:DATA_W-1]) || ~(|v[ACC_W-1:DATA_W-1]))
      return {1'b0, v[DATA_W-1:0]};
    else if (v[ACC_W-1])
      return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? '0 : v;
  endfunction

  logic                     accept, relu_eff, ovf_base;
  logic signed [PROD_W-1:0] prod, prod_sh;
  logic [ACC_W:0]           prod_sat, mac_sat, bias_sat;
  logic [ACC_W-1:0]         acc_base;
  logic [DATA_W:0]          narrow;
  logic [DATA_W-1:0]        result;

  always_comb begin
    accept   = in_valid && in_ready;
    prod     = w_q * in_data;
    prod_sh  = prod >>> FRAC_W;
    prod_sat = sat_acc({prod_sh[PROD_W-1], prod_sh});
    mac_sat  = sat_acc({{(WIDE_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
                     + {{(WIDE_W-ACC_W){prod_sat[ACC_W-1]}}, prod_sat[ACC_W-1:0]});
    // A zero-length neuron takes its bias in IDLE, where the accumulator counts as cleared.
    acc_base = (state_q == IDLE) ? '0 : acc_q;
    ovf_base = (state_q == IDLE) ? 1'b0 : ovf_q;
    relu_eff = (state_q == IDLE) ? relu_en : relu_q;
    bias_sat = sat_acc({{(WIDE_W-ACC_W){acc_base[ACC_W-1]}}, acc_base}
                     + {{(WIDE_W-DATA_W){in_data[DATA_W-1]}}, in_data});
    narrow   = sat_out(bias_sat[ACC_W-1:0]);
    result   = relu_eff ? relu(narrow[DATA_W-1:0]) : narrow[DATA_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    relu_d     = relu_q;
    ovf_d      = ovf_q;
    w_d        = w_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    in_ready   = (state_q != OUT);
    out_valid  = (state_q == OUT);
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: if (accept) begin
        len_d  = length;
        relu_d = relu_en;
        cnt_d  = '0;
        acc_d  = '0;
        ovf_d  = 1'b0;
        if (length == '0) begin
          out_data_d = result;
          ovf_d      = ovf_base | bias_sat[ACC_W] | narrow[DATA_W];
          state_d    = OUT;
        end else begin
          w_d     = in_data;
          state_d = ACT;
        end
      end
      WEIGHT: if (accept) begin
        w_d     = in_data;
        state_d = ACT;
      end
      ACT: if (accept) begin
        acc_d   = mac_sat[ACC_W-1:0];
        ovf_d   = ovf_q | prod_sat[ACC_W] | mac_sat[ACC_W];
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == len_q) ? BIAS : WEIGHT;
      end
      BIAS: if (accept) begin
        out_data_d = result;
        ovf_d      = ovf_base | bias_sat[ACC_W] | narrow[DATA_W];
        state_d    = OUT;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      relu_q     <= 1'b0;
      ovf_q      <= 1'b0;
      w_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      relu_q     <= relu_d;
      ovf_q      <= ovf_d;
      w_q        <= w_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data = out_data_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed bench for dense_layer_engine: hand-computed Q8.24 neurons, flow control and reset.
module tb_dense_layer_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] length;
  logic        relu_en;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  dense_layer_engine dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .length(length), .relu_en(relu_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Present one word for one clock edge; outputs are sampled 1ns after that edge.
  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"},  out_data,           32'd0);
    chk({tag, "_overflow"},  {31'd0, overflow},  32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
  endtask

  task automatic basic_neuron(input string tag);
    length = 16'd3; relu_en = 1'b0; out_ready = 1'b1;
    send(32'h0100_0000);
    length = 16'd7; relu_en = 1'b1;  // must be ignored after the first word
    send(32'h0100_0000);
    send(32'h0200_0000); send(32'h0200_0000);
    send(32'h0300_0000); send(32'h0300_0000);
    chk({tag, "_busy_pre_bias"}, {31'd0, busy}, 32'd1);
    send(32'h1E00_0000);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_out_data"},  out_data,           32'h2C00_0000);
    chk({tag, "_overflow"},  {31'd0, overflow},  32'd0);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    tick();
    chk({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy_idle"},      {31'd0, busy},      32'd1 - 32'd1);
  endtask

  initial begin
    reset = 1'b0; in_data = '0; in_valid = 1'b0; length = '0;
    relu_en = 1'b0; out_ready = 1'b0;
    #12;
    chk_reset_state("reset");
    reset = 1'b1;
    tick();

    basic_neuron("basic");

    // 127*127 exceeds Q8.24 range: clip positive
    length = 16'd1; relu_en = 1'b0; out_ready = 1'b1;
    send(32'h7F00_0000); send(32'h7F00_0000); send(32'h0000_0000);
    chk("sat_pos_data", out_data, 32'h7FFF_FFFF);
    chk("sat_pos_ovf", {31'd0, overflow}, 32'd1);
    tick();

    // -128*127 clips negative, ReLU zeroes it but overflow stays visible
    length = 16'd1; relu_en = 1'b1;
    send(32'h8000_0000); send(32'h7F00_0000); send(32'h0000_0000);
    chk("sat_neg_relu_data", out_data, 32'h0000_0000);
    chk("sat_neg_relu_ovf", {31'd0, overflow}, 32'd1);
    tick();

    // -2*3+1 = -5
    length = 16'd1; relu_en = 1'b1;
    send(32'hFE00_0000); send(32'h0300_0000); send(32'h0100_0000);
    chk("relu_on_data", out_data, 32'h0000_0000);
    chk("relu_on_ovf", {31'd0, overflow}, 32'd0);
    tick();
    length = 16'd1; relu_en = 1'b0;
    send(32'hFE00_0000); send(32'h0300_0000); send(32'h0100_0000);
    chk("relu_off_data", out_data, 32'hFB00_0000);
    tick();

    // zero-length neuron: the only word is the bias
    length = 16'd0; relu_en = 1'b0;
    send(32'h0500_0000);
    chk("zero_len_valid", {31'd0, out_valid}, 32'd1);
    chk("zero_len_data", out_data, 32'h0500_0000);
    chk("zero_len_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("zero_len_busy_drop", {31'd0, busy}, 32'd0);
    chk("zero_len_valid_drop", {31'd0, out_valid}, 32'd0);

    // flow control: input bubble mid-stream, output backpressure
    length = 16'd3; relu_en = 1'b0; out_ready = 1'b0;
    send(32'h0100_0000); send(32'h0100_0000); send(32'h0200_0000);
    tick(); tick();
    chk("fc_gap_busy", {31'd0, busy}, 32'd1);
    chk("fc_gap_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'h0200_0000); send(32'h0300_0000); send(32'h0300_0000);
    send(32'h1E00_0000);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fc_hold%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("fc_hold%0d_data", i), out_data, 32'h2C00_0000);
      chk($sformatf("fc_hold%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      if (i == 0) begin
        in_valid = 1'b1; in_data = 32'h0500_0000; length = 16'd0;
      end
      if (i == 2) out_ready = 1'b1;
      if (i < 2) tick();
    end
    tick();
    chk("fc_handshake_valid", {31'd0, out_valid}, 32'd0);
    chk("fc_handshake_busy", {31'd0, busy}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("fc_next_valid", {31'd0, out_valid}, 32'd1);
    chk("fc_next_data", out_data, 32'h0500_0000);
    tick();

    // asynchronous reset in the middle of a neuron
    length = 16'd3; relu_en = 1'b0;
    send(32'h0100_0000); send(32'h0100_0000); send(32'h0200_0000);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1 chk_reset_state("midreset");
    #2 reset = 1'b1;
    tick();
    basic_neuron("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
